// File: rtl/fetch_unit.sv
// Instruction-fetch and next-PC stage: fetches over a req/ack port, latches the
// instruction word and advances the PC once the current instruction completes.
module fetch_unit #(
  parameter int PC_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic                clk,
  input  logic                rst,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_ack,
  input  logic [PC_WIDTH-1:0] imem_rdata,
  input  logic                stall,
  input  logic                pc_src,
  input  logic                j_cnt,
  input  logic                jr_cnt,
  input  logic                jal_cnt,
  input  logic [PC_WIDTH-1:0] rs_data,
  output logic [PC_WIDTH-1:0] inst,
  output logic [5:0]          opcode,
  output logic [5:0]          func,
  output logic                inst_valid,
  output logic [PC_WIDTH-1:0] pc,
  output logic [PC_WIDTH-1:0] pc_plus4,
  output logic                addr_err,
  output logic [31:0]         retired
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2
  } state_t;

  state_t              state;
  logic [PC_WIDTH-1:0] next_pc;
  logic [PC_WIDTH-1:0] branch_off;

  assign imem_req   = (state == FETCH);
  assign inst_valid = (state == EXEC);
  assign imem_addr  = pc;
  assign pc_plus4   = pc + PC_WIDTH'(4);
  assign opcode     = inst[31:26];
  assign func       = inst[5:0];
  assign branch_off = {{(PC_WIDTH-18){inst[15]}}, inst[15:0], 2'b00};

  // Jump-register outranks the absolute jumps, which outrank a taken branch.
  always_comb begin
    next_pc = pc_plus4;
    if (jr_cnt)
      next_pc = {rs_data[PC_WIDTH-1:2], 2'b00};
    else if (j_cnt || jal_cnt)
      next_pc = {pc_plus4[PC_WIDTH-1:28], inst[25:0], 2'b00};
    else if (pc_src)
      next_pc = pc_plus4 + branch_off;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      inst     <= '0;
      retired  <= '0;
      addr_err <= 1'b0;
    end else begin
      addr_err <= 1'b0;
      case (state)
        IDLE: state <= FETCH;
        FETCH: begin
          if (imem_ack) begin
            inst  <= imem_rdata;
            state <= EXEC;
          end
        end
        EXEC: begin
          if (!stall) begin
            pc       <= next_pc;
            retired  <= retired + 32'd1;
            addr_err <= jr_cnt && (rs_data[1:0] != 2'b00);
            state    <= FETCH;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: expected fetch addresses are queued as each
// instruction is steered and checked when the unit issues the next request.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        stall = 1'b0;
  logic        pc_src = 1'b0;
  logic        j_cnt = 1'b0;
  logic        jr_cnt = 1'b0;
  logic        jal_cnt = 1'b0;
  logic [31:0] rs_data = '0;
  logic [31:0] inst;
  logic [5:0]  opcode;
  logic [5:0]  func;
  logic        inst_valid;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        addr_err;
  logic [31:0] retired;

  int          compared = 0;
  int          mismatched = 0;
  logic [31:0] exp_addr[$];
  logic [31:0] exp_retired = 0;

  fetch_unit #(.PC_WIDTH(32), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .stall(stall),
    .pc_src(pc_src), .j_cnt(j_cnt), .jr_cnt(jr_cnt), .jal_cnt(jal_cnt),
    .rs_data(rs_data), .inst(inst), .opcode(opcode), .func(func),
    .inst_valid(inst_valid), .pc(pc), .pc_plus4(pc_plus4),
    .addr_err(addr_err), .retired(retired)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Pops the next expected fetch address once the unit is requesting.
  task automatic checkFetchAddr(output logic [31:0] e);
    int n = 0;
    while (!imem_req && n < 20) begin
      tick();
      n++;
    end
    checkOutput("imem_req", {31'b0, imem_req}, 32'd1);
    if (exp_addr.size() > 0) e = exp_addr.pop_front();
    else e = 32'hxxxx_xxxx;
    checkOutput("fetch_addr", imem_addr, e);
  endtask

  task automatic fetchWord(input int wait_cycles, input logic [31:0] word);
    logic [31:0] e;
    checkFetchAddr(e);
    for (int i = 0; i < wait_cycles; i++) begin
      tick();
      checkOutput("addr_stable", imem_addr, e);
      checkOutput("req_held", {31'b0, imem_req}, 32'd1);
    end
    imem_ack   = 1'b1;
    imem_rdata = word;
    tick();
    imem_ack   = 1'b0;
    imem_rdata = '0;
    checkOutput("inst", inst, word);
    checkOutput("inst_valid", {31'b0, inst_valid}, 32'd1);
    checkOutput("pc", pc, e);
  endtask

  // Drives the controller decision for one EXEC cycle.
  task automatic applyStimulus(input logic st, input logic br, input logic j, input logic jr,
                               input logic jal, input logic [31:0] rs, input logic [31:0] next_addr);
    stall = st; pc_src = br; j_cnt = j; jr_cnt = jr; jal_cnt = jal; rs_data = rs;
    if (!st) begin
      exp_addr.push_back(next_addr);
      exp_retired++;
    end
    tick();
    stall = 1'b0; pc_src = 1'b0; j_cnt = 1'b0; jr_cnt = 1'b0; jal_cnt = 1'b0; rs_data = '0;
    checkOutput("retired", retired, exp_retired);
  endtask

  initial begin
    logic [31:0] e;
    tick();
    tick();
    checkOutput("rst_req", {31'b0, imem_req}, 32'd0);
    checkOutput("rst_valid", {31'b0, inst_valid}, 32'd0);
    checkOutput("rst_addr", imem_addr, 32'h0);
    checkOutput("rst_pc_plus4", pc_plus4, 32'h4);
    checkOutput("rst_inst", inst, 32'h0);
    checkOutput("rst_retired", retired, 32'h0);
    checkOutput("rst_addr_err", {31'b0, addr_err}, 32'd0);
    rst = 1'b0;

    $display("[TB] add with zero-wait ack");
    exp_addr.push_back(32'h0);
    fetchWord(0, 32'h0000_0020);
    checkOutput("opcode", {26'b0, opcode}, 32'h0);
    checkOutput("func", {26'b0, func}, 32'h20);
    applyStimulus(0, 0, 0, 0, 0, 0, 32'h4);
    fetchWord(0, 32'h0);
    applyStimulus(0, 0, 0, 0, 0, 0, 32'h8);

    $display("[TB] beq taken and not taken");
    fetchWord(0, 32'h1000_FFFE);
    applyStimulus(0, 1, 0, 0, 0, 0, 32'h4);
    fetchWord(0, 32'h0);
    applyStimulus(0, 0, 0, 0, 0, 0, 32'h8);
    fetchWord(0, 32'h1000_FFFE);
    applyStimulus(0, 0, 0, 0, 0, 0, 32'hC);

    $display("[TB] j, then jal with jr");
    fetchWord(0, 32'h0000_0008);
    applyStimulus(0, 0, 0, 1, 0, 32'h1000_0000, 32'h1000_0000);
    fetchWord(0, 32'h0800_0040);
    applyStimulus(0, 0, 1, 0, 0, 0, 32'h1000_0100);
    fetchWord(0, 32'h0C00_0040);
    checkOutput("pc_plus4", pc_plus4, 32'h1000_0104);
    applyStimulus(0, 0, 0, 1, 1, 32'h200, 32'h200);

    $display("[TB] misaligned jr");
    fetchWord(0, 32'h0000_0008);
    checkOutput("addr_err_pre", {31'b0, addr_err}, 32'd0);
    applyStimulus(0, 0, 0, 1, 0, 32'h203, 32'h200);
    checkOutput("addr_err_pulse", {31'b0, addr_err}, 32'd1);
    tick();
    checkOutput("addr_err_drop", {31'b0, addr_err}, 32'd0);

    $display("[TB] delayed ack and stall");
    fetchWord(3, 32'h0000_0020);
    applyStimulus(1, 0, 0, 0, 0, 0, 32'h0);
    checkOutput("stall_valid1", {31'b0, inst_valid}, 32'd1);
    checkOutput("stall_pc1", pc, 32'h200);
    applyStimulus(1, 0, 0, 0, 0, 0, 32'h0);
    checkOutput("stall_valid2", {31'b0, inst_valid}, 32'd1);
    checkOutput("stall_addr2", imem_addr, 32'h200);
    applyStimulus(0, 0, 0, 0, 0, 0, 32'h204);
    checkOutput("post_stall_valid", {31'b0, inst_valid}, 32'd0);
    checkFetchAddr(e);

    $display("[TB] reset during fetch");
    rst = 1'b1;
    #1;
    checkOutput("rst_fetch_req", {31'b0, imem_req}, 32'd0);
    checkOutput("rst_fetch_pc", pc, 32'h0);
    exp_retired = 0;
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    tick();
    rst = 1'b0;
    tick();
    imem_ack   = 1'b0;
    imem_rdata = '0;
    checkOutput("rst_inst_kept", inst, 32'h0);
    checkOutput("rst_retired0", retired, 32'h0);
    exp_addr.push_back(32'h0);
    fetchWord(0, 32'h0000_0008);

    $display("[TB] pc wrap");
    applyStimulus(0, 0, 0, 1, 0, 32'hFFFF_FFFC, 32'hFFFF_FFFC);
    fetchWord(1, 32'h0);
    checkOutput("wrap_pc_plus4", pc_plus4, 32'h0);
    applyStimulus(0, 0, 0, 0, 0, 0, 32'h0);
    checkFetchAddr(e);
    checkOutput("sb_drained", exp_addr.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
